// File: rtl/uart_pkg.sv
// ============================================================================
// uart_pkg : shared constants and state encoding for the UART TX arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        WAIT_HI = 3'd2,
        WAIT_LO = 3'd3,
        DONE    = 3'd4
    } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_pick.sv
// ============================================================================
// rr_pick : combinational round-robin selector, first request after ptr
// Rev 1.0
// ============================================================================
`default_nettype none

module rr_pick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        // Offsets 1..N visit ptr+1 first and ptr itself last
        for (int k = 1; k <= N; k++) begin
            if (!any && req[(int'(ptr) + k) % N]) begin
                any                       = 1'b1;
                gnt[(int'(ptr) + k) % N]  = 1'b1;
                idx                       = IW'((int'(ptr) + k) % N);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// ============================================================================
// uart_tx_arbiter : packet-level round-robin sharing of one UART transmitter
// Rev 1.0
// ============================================================================
`default_nettype none

module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int BUSY_TO = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [8*N_REQ-1:0]    req_data,
    input  logic [N_REQ-1:0]      req_last,
    output logic [N_REQ-1:0]      req_ready,
    output logic [N_REQ-1:0]      grant,
    output logic                  uart_trig,
    output logic [BYTE_W-1:0]     uart_tx_data,
    input  logic                  uart_tx_busy,
    output logic                  timeout_err
);

    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(BUSY_TO + 1);

    arb_state_t          r_state, w_state_nxt;
    logic [IW-1:0]       r_ptr, w_ptr_nxt;
    logic [IW-1:0]       r_gidx, w_gidx_nxt;
    logic                r_last, w_last_nxt;
    logic [CW-1:0]       r_cnt, w_cnt_nxt;
    logic [N_REQ-1:0]    w_grant_nxt, w_ready_nxt;
    logic                w_trig_nxt, w_tout_nxt;
    logic [BYTE_W-1:0]   w_data_nxt;

    logic [N_REQ-1:0]    w_pick_gnt;
    logic [IW-1:0]       w_pick_idx;
    logic                w_pick_any;
    logic [BYTE_W-1:0]   w_lane [N_REQ];

    generate
        for (genvar i = 0; i < N_REQ; i++) begin : g_lane
            assign w_lane[i] = req_data[i*BYTE_W +: BYTE_W];
        end
    endgenerate

    rr_pick #(
        .N  (N_REQ),
        .IW (IW)
    ) u_rr_pick (
        .req (req_valid),
        .ptr (r_ptr),
        .gnt (w_pick_gnt),
        .idx (w_pick_idx),
        .any (w_pick_any)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_gidx_nxt  = r_gidx;
        w_last_nxt  = r_last;
        w_cnt_nxt   = r_cnt;
        w_grant_nxt = grant;
        w_ready_nxt = '0;
        w_trig_nxt  = 1'b0;
        w_tout_nxt  = 1'b0;
        w_data_nxt  = uart_tx_data;

        unique case (r_state)
            IDLE: begin
                if (w_pick_any) begin
                    w_grant_nxt = w_pick_gnt;
                    w_gidx_nxt  = w_pick_idx;
                    w_state_nxt = LOAD;
                end
            end
            LOAD: begin
                // Owner gaps stall here indefinitely; grant is never revoked mid-packet
                if (req_valid[r_gidx] && !uart_tx_busy) begin
                    w_data_nxt  = w_lane[r_gidx];
                    w_last_nxt  = req_last[r_gidx];
                    w_ready_nxt = grant;
                    w_trig_nxt  = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = WAIT_HI;
                end
            end
            WAIT_HI: begin
                if (uart_tx_busy) begin
                    w_state_nxt = WAIT_LO;
                end else if (r_cnt == CW'(BUSY_TO - 1)) begin
                    w_tout_nxt  = 1'b1;
                    w_state_nxt = DONE;
                end else begin
                    w_cnt_nxt   = r_cnt + 1'b1;
                end
            end
            WAIT_LO: begin
                if (!uart_tx_busy) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (r_last) begin
                    w_ptr_nxt   = r_gidx;
                    w_grant_nxt = '0;
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = LOAD;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_ptr        <= IW'(N_REQ - 1);
            r_gidx       <= '0;
            r_last       <= 1'b0;
            r_cnt        <= '0;
            grant        <= '0;
            req_ready    <= '0;
            uart_trig    <= 1'b0;
            timeout_err  <= 1'b0;
            uart_tx_data <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_ptr        <= w_ptr_nxt;
            r_gidx       <= w_gidx_nxt;
            r_last       <= w_last_nxt;
            r_cnt        <= w_cnt_nxt;
            grant        <= w_grant_nxt;
            req_ready    <= w_ready_nxt;
            uart_trig    <= w_trig_nxt;
            timeout_err  <= w_tout_nxt;
            uart_tx_data <= w_data_nxt;
        end
    end

endmodule

`default_nettype wire
